// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher sequencer.
//   WORD_W / KEY_WORDS : word width and number of key segments per key
//   KEY_W              : full assembled key width
//   SEG_IDX_W          : width of slot / segment indices
//   state_e            : sequencer FSM encoding (exposed on oState)
//   key_segment()      : selects one WORD_W slice of the assembled key
package xor_cipher_pkg;

  localparam int WORD_W    = 32;
  localparam int KEY_WORDS = 16;
  localparam int KEY_W     = WORD_W * KEY_WORDS;
  localparam int SEG_IDX_W = $clog2(KEY_WORDS);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  localparam logic [SEG_IDX_W-1:0] LAST_IDX = SEG_IDX_W'(KEY_WORDS - 1);

  function automatic logic [WORD_W-1:0] key_segment(
    input logic [KEY_W-1:0]     key,
    input logic [SEG_IDX_W-1:0] seg
  );
    return key[seg*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/xor_cipher_sequencer_if.sv
// Stream bundle for the XOR cipher sequencer.
//   iKey_word/iKey_valid/oKey_ready : incoming key words
//   iData/iData_valid/oData_ready   : plaintext words
//   oCipher/oCipher_valid/iCipher_ready : ciphertext words
// Handshake rule for all three channels: a transfer happens on a rising
// clock edge where valid and ready are both 1; a producer holds its
// payload and valid stable until that transfer.
// slave modport = sequencer view, master modport = environment view.
interface xor_cipher_sequencer_if;
  import xor_cipher_pkg::*;

  logic [WORD_W-1:0] iKey_word;
  logic              iKey_valid;
  logic              oKey_ready;
  logic [WORD_W-1:0] iData;
  logic              iData_valid;
  logic              oData_ready;
  logic [WORD_W-1:0] oCipher;
  logic              oCipher_valid;
  logic              iCipher_ready;

  modport slave (
    input  iKey_word, iKey_valid, iData, iData_valid, iCipher_ready,
    output oKey_ready, oData_ready, oCipher, oCipher_valid
  );

  modport master (
    output iKey_word, iKey_valid, iData, iData_valid, iCipher_ready,
    input  oKey_ready, oData_ready, oCipher, oCipher_valid
  );
endinterface

// File: rtl/xor_cipher_out_stage.sv
// Registered ciphertext holding stage.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i         : accepted plaintext word this cycle (only when can_accept_o)
//   data_i         : plaintext word
//   key_i, seg_i   : assembled key and segment used for this word
//   ready_i        : downstream ready
//   cipher_o       : registered ciphertext
//   valid_o        : ciphertext valid
//   can_accept_o   : stage is empty or being emptied this cycle
module xor_cipher_out_stage
  import xor_cipher_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [WORD_W-1:0]    data_i,
  input  logic [KEY_W-1:0]     key_i,
  input  logic [SEG_IDX_W-1:0] seg_i,
  input  logic                 ready_i,
  output logic [WORD_W-1:0]    cipher_o,
  output logic                 valid_o,
  output logic                 can_accept_o
);

  logic [WORD_W-1:0] cipher_q;
  logic              valid_q;

  assign can_accept_o = !valid_q || ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cipher_q <= '0;
      valid_q  <= 1'b0;
    end else if (load_i) begin
      cipher_q <= data_i ^ key_segment(key_i, seg_i);
      valid_q  <= 1'b1;
    end else if (ready_i) begin
      // Output transfer with no replacement word: stage empties.
      valid_q  <= 1'b0;
    end
  end

  assign cipher_o = cipher_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/xor_cipher_sequencer.sv
// XOR cipher sequencer: loads a KEY_WORDS-word key into an external
// assembler slot by slot, then encrypts a data stream against the
// assembled key, rotating through the segments. iRekey drains any held
// ciphertext and restarts key loading.
//   iClk, iRst        : clock, synchronous active-high reset
//   bus (slave)       : key / plaintext / ciphertext streams
//   oKey_load/oKey_slot/oKey_data : assembler word-write port
//   iAssembled_key    : assembler contents
//   iRekey            : level request for a new key
//   oCan_encrypt      : high in RUN
//   oState            : FSM state (0 LOAD, 1 SETTLE, 2 RUN, 3 DRAIN)
//   oBlock_count      : only with XOR_CIPHER_STATS_EN; count of full
//                       segment rotations, saturating, cleared on LOAD
module xor_cipher_sequencer
  import xor_cipher_pkg::*;
(
  input  logic                   iClk,
  input  logic                   iRst,
  xor_cipher_sequencer_if.slave  bus,
  output logic                   oKey_load,
  output logic [SEG_IDX_W-1:0]   oKey_slot,
  output logic [WORD_W-1:0]      oKey_data,
  input  logic [KEY_W-1:0]       iAssembled_key,
  input  logic                   iRekey,
  output logic                   oCan_encrypt,
`ifdef XOR_CIPHER_STATS_EN
  output logic [15:0]            oBlock_count,
`endif
  output logic [1:0]             oState
);

  state_e                 state_q, state_d;
  logic [SEG_IDX_W-1:0]   count_q, count_d;
  logic [SEG_IDX_W-1:0]   seg_q, seg_d;
  logic                   key_load_q, key_load_d;
  logic [SEG_IDX_W-1:0]   key_slot_q, key_slot_d;
  logic [WORD_W-1:0]      key_data_q, key_data_d;

  logic key_hs;
  logic data_hs;
  logic out_hs;
  logic stage_can_accept;

  assign bus.oKey_ready  = (state_q == S_LOAD);
  assign bus.oData_ready = (state_q == S_RUN) && stage_can_accept;

  // A key word arriving together with iRekey is dropped.
  assign key_hs  = bus.iKey_valid && bus.oKey_ready && !iRekey;
  assign data_hs = bus.iData_valid && bus.oData_ready;
  assign out_hs  = bus.oCipher_valid && bus.iCipher_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    seg_d      = seg_q;
    key_load_d = 1'b0;
    key_slot_d = key_slot_q;
    key_data_d = key_data_q;
    case (state_q)
      S_LOAD: begin
        if (iRekey) begin
          count_d = '0;
        end else if (key_hs) begin
          key_load_d = 1'b1;
          key_slot_d = count_q;
          key_data_d = bus.iKey_word;
          count_d    = (count_q == LAST_IDX) ? '0 : count_q + 1'b1;
          if (count_q == LAST_IDX) state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (iRekey) begin
          count_d = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The data word accepted alongside iRekey still goes out.
        if (data_hs) seg_d = (seg_q == LAST_IDX) ? '0 : seg_q + 1'b1;
        if (iRekey)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.oCipher_valid || out_hs) begin
          state_d = S_LOAD;
          count_d = '0;
          seg_d   = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_LOAD;
      count_q    <= '0;
      seg_q      <= '0;
      key_load_q <= 1'b0;
      key_slot_q <= '0;
      key_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      seg_q      <= seg_d;
      key_load_q <= key_load_d;
      key_slot_q <= key_slot_d;
      key_data_q <= key_data_d;
    end
  end

  xor_cipher_out_stage u_out_stage (
    .clk_i        (iClk),
    .rst_i        (iRst),
    .load_i       (data_hs),
    .data_i       (bus.iData),
    .key_i        (iAssembled_key),
    .seg_i        (seg_q),
    .ready_i      (bus.iCipher_ready),
    .cipher_o     (bus.oCipher),
    .valid_o      (bus.oCipher_valid),
    .can_accept_o (stage_can_accept)
  );

`ifdef XOR_CIPHER_STATS_EN
  logic [15:0] blk_q, blk_d;

  always_comb begin
    blk_d = blk_q;
    // No words are accepted while in LOAD, so clearing on every
    // LOAD-bound cycle is equivalent to clearing on entry.
    if (state_d == S_LOAD) begin
      blk_d = '0;
    end else if (data_hs && (seg_q == LAST_IDX) && (blk_q != 16'hFFFF)) begin
      blk_d = blk_q + 16'd1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) blk_q <= '0;
    else      blk_q <= blk_d;
  end

  assign oBlock_count = blk_q;
`endif

  assign oKey_load    = key_load_q;
  assign oKey_slot    = key_slot_q;
  assign oKey_data    = key_data_q;
  assign oCan_encrypt = (state_q == S_RUN);
  assign oState       = state_q;

endmodule

// File: tb/tb_xor_cipher_sequencer.sv
module tb_xor_cipher_sequencer;

  logic         iClk;
  logic         iRst;
  logic         oKey_load;
  logic [3:0]   oKey_slot;
  logic [31:0]  oKey_data;
  logic [511:0] iAssembled_key;
  logic         iRekey;
  logic         oCan_encrypt;
  logic [1:0]   oState;
`ifdef XOR_CIPHER_STATS_EN
  logic [15:0]  oBlock_count;
`endif

  int checks   = 0;
  int failures = 0;

  xor_cipher_sequencer_if bus ();

  xor_cipher_sequencer dut (
    .iClk           (iClk),
    .iRst           (iRst),
    .bus            (bus),
    .oKey_load      (oKey_load),
    .oKey_slot      (oKey_slot),
    .oKey_data      (oKey_data),
    .iAssembled_key (iAssembled_key),
    .iRekey         (iRekey),
    .oCan_encrypt   (oCan_encrypt),
`ifdef XOR_CIPHER_STATS_EN
    .oBlock_count   (oBlock_count),
`endif
    .oState         (oState)
  );

  // Clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Key slot k holds 0xA5A5A500 | k.
  function automatic logic [31:0] exp_c(input logic [31:0] d, input int seg);
    logic [31:0] s;
    s = 32'(seg % 16);
    return d ^ (32'hA5A5A500 | s);
  endfunction

  task automatic load_key(input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      bus.iKey_word  = base + 32'(i);
      bus.iKey_valid = 1'b1;
      tick();
      chk("key_load", 32'(oKey_load), 32'd1);
      chk("key_slot", 32'(oKey_slot), 32'(i));
      chk("key_data", oKey_data, base + 32'(i));
      chk("load_state", 32'(oState), (i == 15) ? 32'd1 : 32'd0);
    end
    bus.iKey_valid = 1'b0;
  endtask

  initial begin
    int seg;
    for (int k = 0; k < 16; k++) iAssembled_key[k*32 +: 32] = 32'hA5A5A500 | 32'(k);
    bus.iKey_word = '0; bus.iKey_valid = 1'b0;
    bus.iData = '0; bus.iData_valid = 1'b0; bus.iCipher_ready = 1'b0;
    iRekey = 1'b0;
    iRst = 1'b1;
    tick();
    tick();
    iRst = 1'b0;

    // Reset state
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_key_load", 32'(oKey_load), 32'd0);
    chk("rst_key_slot", 32'(oKey_slot), 32'd0);
    chk("rst_key_data", oKey_data, 32'd0);
    chk("rst_cipher", bus.oCipher, 32'd0);
    chk("rst_cvalid", 32'(bus.oCipher_valid), 32'd0);
    chk("rst_can_enc", 32'(oCan_encrypt), 32'd0);
    chk("rst_key_ready", 32'(bus.oKey_ready), 32'd1);
    chk("rst_data_ready", 32'(bus.oData_ready), 32'd0);

    // Load key words 0..15, then SETTLE -> RUN
    load_key(32'h0);
    #1;
    chk("settle_can_enc", 32'(oCan_encrypt), 32'd0);
    chk("settle_key_ready", 32'(bus.oKey_ready), 32'd0);
    tick();
    chk("run_state", 32'(oState), 32'd2);
    chk("run_can_enc", 32'(oCan_encrypt), 32'd1);
    chk("run_key_load", 32'(oKey_load), 32'd0);

    // Stream 0x0..0x11 at full rate
    bus.iCipher_ready = 1'b1;
    seg = 0;
    for (int d = 0; d < 18; d++) begin
      bus.iData = 32'(d);
      bus.iData_valid = 1'b1;
      #1;
      chk("stream_dready", 32'(bus.oData_ready), 32'd1);
      tick();
      chk("stream_cvalid", 32'(bus.oCipher_valid), 32'd1);
      chk("stream_cipher", bus.oCipher, exp_c(32'(d), seg));
      seg++;
    end
    chk("wrap_cipher17", bus.oCipher, 32'hA5A5A510);
    bus.iData_valid = 1'b0;
    tick();
    chk("stream_drain_cvalid", 32'(bus.oCipher_valid), 32'd0);

    // Backpressure for 5 cycles
    bus.iCipher_ready = 1'b0;
    bus.iData = 32'h100;
    bus.iData_valid = 1'b1;
    #1;
    chk("bp_dready_empty", 32'(bus.oData_ready), 32'd1);
    tick();
    chk("bp_first", bus.oCipher, exp_c(32'h100, seg));
    chk("bp_first_valid", 32'(bus.oCipher_valid), 32'd1);
    bus.iData = 32'h1234;
    #1;
    chk("bp_dready_full", 32'(bus.oData_ready), 32'd0);
    repeat (5) begin
      tick();
      chk("bp_hold_cipher", bus.oCipher, exp_c(32'h100, seg));
      chk("bp_hold_valid", 32'(bus.oCipher_valid), 32'd1);
      chk("bp_hold_dready", 32'(bus.oData_ready), 32'd0);
    end
    seg++;
    bus.iCipher_ready = 1'b1;
    #1;
    chk("bp_release_dready", 32'(bus.oData_ready), 32'd1);
    tick();
    chk("bp_next_cipher", bus.oCipher, exp_c(32'h1234, seg));
    chk("bp_next_valid", 32'(bus.oCipher_valid), 32'd1);
    seg++;
    bus.iData_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(bus.oCipher_valid), 32'd0);

    // Rekey with simultaneous data handshake, output backpressured
    bus.iCipher_ready = 1'b0;
    bus.iData = 32'hCAFE0000;
    bus.iData_valid = 1'b1;
    iRekey = 1'b1;
    tick();
    chk("rk_state_drain", 32'(oState), 32'd3);
    chk("rk_cipher", bus.oCipher, exp_c(32'hCAFE0000, seg));
    chk("rk_cvalid", 32'(bus.oCipher_valid), 32'd1);
    chk("rk_can_enc", 32'(oCan_encrypt), 32'd0);
    bus.iData_valid = 1'b0;
    iRekey = 1'b0;
    #1;
    chk("drain_dready", 32'(bus.oData_ready), 32'd0);
    chk("drain_kready", 32'(bus.oKey_ready), 32'd0);
    repeat (3) begin
      tick();
      chk("drain_hold_state", 32'(oState), 32'd3);
      chk("drain_hold_cipher", bus.oCipher, exp_c(32'hCAFE0000, seg));
    end
    bus.iCipher_ready = 1'b1;
    tick();
    chk("drain_done_state", 32'(oState), 32'd0);
    chk("drain_done_cvalid", 32'(bus.oCipher_valid), 32'd0);
    chk("drain_done_can_enc", 32'(oCan_encrypt), 32'd0);
    bus.iCipher_ready = 1'b0;

    // Partial load of 7 words, then rekey drops the concurrent word
    for (int i = 0; i < 7; i++) begin
      bus.iKey_word = 32'h100 + 32'(i);
      bus.iKey_valid = 1'b1;
      tick();
      chk("part_key_load", 32'(oKey_load), 32'd1);
      chk("part_key_slot", 32'(oKey_slot), 32'(i));
    end
    bus.iKey_word = 32'h77;
    iRekey = 1'b1;
    tick();
    chk("rekey_drop_load", 32'(oKey_load), 32'd0);
    chk("rekey_state", 32'(oState), 32'd0);
    iRekey = 1'b0;
    load_key(32'h200);
    tick();
    chk("reload_run", 32'(oState), 32'd2);

    // Segment restarts at 0 after rekey; hold a word, then reset
    bus.iData = 32'h42;
    bus.iData_valid = 1'b1;
    tick();
    chk("seg_restart_cipher", bus.oCipher, exp_c(32'h42, 0));
    chk("pre_rst_cvalid", 32'(bus.oCipher_valid), 32'd1);
    bus.iData_valid = 1'b0;
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk("mid_rst_state", 32'(oState), 32'd0);
    chk("mid_rst_key_load", 32'(oKey_load), 32'd0);
    chk("mid_rst_key_slot", 32'(oKey_slot), 32'd0);
    chk("mid_rst_key_data", oKey_data, 32'd0);
    chk("mid_rst_cipher", bus.oCipher, 32'd0);
    chk("mid_rst_cvalid", 32'(bus.oCipher_valid), 32'd0);
    chk("mid_rst_can_enc", 32'(oCan_encrypt), 32'd0);

`ifdef XOR_CIPHER_STATS_EN
    chk("blk_rst", 32'(oBlock_count), 32'd0);
    load_key(32'h300);
    tick();
    bus.iCipher_ready = 1'b1;
    for (int d = 0; d < 40; d++) begin
      bus.iData = 32'(d);
      bus.iData_valid = 1'b1;
      tick();
    end
    bus.iData_valid = 1'b0;
    tick();
    chk("blk_count_40", 32'(oBlock_count), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_cipher_sequencer.md
Name: xor_cipher_sequencer

Overview:
- Controller for the XOR cipher datapath.
- Accepts 32-bit key words over a valid/ready handshake and drives the key assembler's word-write port, slot by slot, until a 512-bit key is built.
- Then schedules data words against the assembled key, rotating through the 16 key segments, and emits ciphertext through a one-stage registered output.
- Supports rekeying mid-stream by draining in-flight output first.

Parameters:
- WORD_W, 32, width of key/data/cipher words.
- KEY_WORDS, 16, key segments per full key (key width = WORD_W*KEY_WORDS = 512).

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iKey_word  in  32  incoming key word.
- iKey_valid  in  1  key word valid.
- oKey_ready  out  1  sequencer accepts key word.
- oKey_load  out  1  one-cycle write strobe to the assembler.
- oKey_slot  out  4  segment index written by oKey_load.
- oKey_data  out  32  registered key word written by oKey_load.
- iAssembled_key  in  512  key contents returned by the assembler.
- iRekey  in  1  request for a new key (level, sampled each cycle).
- iData  in  32  plaintext word.
- iData_valid  in  1  plaintext valid.
- oData_ready  out  1  plaintext accepted.
- oCipher  out  32  ciphertext word.
- oCipher_valid  out  1  ciphertext valid.
- iCipher_ready  in  1  downstream accepts ciphertext.
- oCan_encrypt  out  1  key complete, encryption enabled.
- oState  out  2  FSM state: 0=LOAD, 1=SETTLE, 2=RUN, 3=DRAIN.

Behaviour:
- **Reset.** Synchronous active-high on iRst. While iRst=1 at a clock edge, the next state is:
  - state=LOAD, word count=0, segment index=0;
  - oKey_load=0, oKey_slot=0, oKey_data=0;
  - oCipher=0, oCipher_valid=0, oCan_encrypt=0;
  - stats counter=0.
  - Reset mid-load or mid-run discards all progress; no drain is performed.
- **LOAD.** oKey_ready=1 and oData_ready=0.
  - On each key handshake (iKey_valid & oKey_ready), the next cycle has oKey_load=1, oKey_slot=count, oKey_data=iKey_word, and count increments.
  - On the handshake where count==15, the FSM goes to SETTLE.
- **SETTLE.** One cycle; lets the final assembler write land. oKey_ready=0. Next state is RUN, and oCan_encrypt rises on entry to RUN.
- **RUN.** oCan_encrypt=1 and oKey_ready=0. oData_ready = !oCipher_valid | iCipher_ready.
  - On a data handshake, the next cycle has oCipher = iData ^ iAssembled_key[seg*32 +: 32] and oCipher_valid=1.
  - seg increments and wraps 15→0.
  - oCipher_valid clears on an output handshake that has no simultaneous new data handshake.
  - With continuous valid and ready, throughput is one word per cycle at latency 1.
- **iRekey in RUN.** A data handshake in the same cycle is still completed. The FSM then enters DRAIN.
- **DRAIN.** oData_ready=0, oKey_ready=0, oCan_encrypt=0. Hold until oCipher_valid=0 or the final output handshake occurs, then go to LOAD with count=0 and seg=0.
- **iRekey in LOAD or SETTLE.** Count restarts at 0 and the FSM returns to LOAD. A key handshake in that same cycle is dropped (no oKey_load pulse).
- **Held outputs.** oCipher holds while oCipher_valid=1 && !iCipher_ready; there is no data loss under backpressure.
- **oKey_load** is never asserted outside the cycle following a LOAD-state handshake.

Optional Feature:
- Macro: XOR_CIPHER_STATS_EN.
- When defined, adds output port oBlock_count[15:0]. It increments each time seg wraps 15→0 on an accepted word, saturates at 0xFFFF, and clears on reset and on entry to LOAD.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package xor_cipher_pkg holds:
  - WORD_W and KEY_WORDS;
  - KEY_W = WORD_W*KEY_WORDS;
  - SEG_IDX_W = $clog2(KEY_WORDS);
  - FSM state encoding constants S_LOAD/S_SETTLE/S_RUN/S_DRAIN.
- One sub-module is natural: xor_cipher_out_stage, the registered ciphertext holding stage with valid/ready and the XOR/segment mux. The FSM and counters stay in the top.

Test Plan:
1. Reset, then feed 16 key words 0x00000000..0x0000000F back to back → oKey_load pulses 16 cycles with slots 0..15; state goes SETTLE then RUN; oCan_encrypt=1 two cycles after the 16th handshake.
2. With iAssembled_key slot k = 0xA5A5A500|k, stream data 0x0..0x11 with iCipher_ready=1 → oCipher = data ^ key[seg], seg wraps after 16, one word per cycle, latency 1.
3. Hold iCipher_ready=0 for 5 cycles mid-stream → oData_ready=0 after the first held word; oCipher stays stable; no word is lost or duplicated on release.
4. Pulse iRekey with a data handshake in the same cycle while output is backpressured → that word is emitted; DRAIN holds until it is consumed; then LOAD with oCan_encrypt=0 and slots restarting at 0.
5. Pulse iRekey after 7 key words in LOAD → the next oKey_slot is 0, and a full 16 further words are needed to reach RUN.
6. Assert iRst during RUN with oCipher_valid=1 → next cycle all outputs are at reset values and state=LOAD. With XOR_CIPHER_STATS_EN: after 40 words, oBlock_count=2.
